// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and two
// peripherals (p0 = MIDI event writer, p1 = voice-engine parameter reader).
// The CPU has fixed priority. A starvation counter forces one peripheral slot
// (stalling the CPU) after STARVE_LIMIT blocked cycles. The peripherals
// alternate round-robin among themselves.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_access,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_CPU,
        SLOT_P0,
        SLOT_P1
    } slot_t;

    slot_t       slot;
    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [1:0]  gnt_vec;
    logic [1:0]  rvalid_vec;
    logic        force_slot;
    logic        pick_p1;
    logic        last_reg, last_next;
    logic [7:0]  starve_cnt_reg, starve_cnt_next;

    assign req_vec = {p1_req, p0_req};
    assign we_vec  = {p1_we, p0_we};

    // Read data is never buffered; everyone sees the RAM output directly.
    assign cpu_rdata = ram_dataOut;
    assign p0_rdata  = ram_dataOut;
    assign p1_rdata  = ram_dataOut;

    // Slot owner selection; reset holds the slot idle so nothing is granted.
    always_comb begin
        slot       = SLOT_IDLE;
        force_slot = (starve_cnt_reg >= LIMIT) && (|req_vec);
        // With both requesting, the port not granted last time wins.
        pick_p1    = req_vec[1] && (!req_vec[0] || !last_reg);
        if (reset) begin
            slot = SLOT_IDLE;
        end else if (force_slot) begin
            slot = pick_p1 ? SLOT_P1 : SLOT_P0;
        end else if (cpu_access) begin
            slot = SLOT_CPU;
        end else if (|req_vec) begin
            slot = pick_p1 ? SLOT_P1 : SLOT_P0;
        end
    end

    // RAM port mux, grants and the CPU stall derived from the slot owner.
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        gnt_vec    = 2'b00;
        cpu_stall  = 1'b0;
        case (slot)
            SLOT_CPU: begin
                ram_wEn    = cpu_wren;
                ram_addr   = cpu_addr;
                ram_dataIn = cpu_wdata;
            end
            SLOT_P0: begin
                ram_wEn    = p0_we;
                ram_addr   = p0_addr;
                ram_dataIn = p0_wdata;
                gnt_vec[0] = 1'b1;
                cpu_stall  = cpu_access;
            end
            SLOT_P1: begin
                ram_wEn    = p1_we;
                ram_addr   = p1_addr;
                ram_dataIn = p1_wdata;
                gnt_vec[1] = 1'b1;
                cpu_stall  = cpu_access;
            end
            default: ;
        endcase
        // A peripheral can only take the slot from an accessing CPU when forced.
        if (!force_slot) cpu_stall = 1'b0;
    end

    assign p0_gnt = gnt_vec[0];
    assign p1_gnt = gnt_vec[1];

    // Next-state for the round-robin pointer and the saturating starve counter.
    always_comb begin
        last_next       = last_reg;
        starve_cnt_next = starve_cnt_reg;
        if (gnt_vec[1]) begin
            last_next = 1'b1;
        end else if (gnt_vec[0]) begin
            last_next = 1'b0;
        end
        if (|gnt_vec || !(|req_vec)) begin
            starve_cnt_next = 8'd0;
        end else if (starve_cnt_reg != 8'hFF) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
        end
    end

    // Arbitration state; last starts at p1 so p0 wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_reg       <= 1'b1;
            starve_cnt_reg <= 8'd0;
        end else begin
            last_reg       <= last_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Per-port read-valid flag: set the cycle after a granted read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic rvalid_reg;
            // Registered read-valid; asynchronously dropped on reset.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= gnt_vec[gi] & ~we_vec[gi];
                end
            end
            assign rvalid_vec[gi] = rvalid_reg;
        end
    endgenerate

    assign p0_rvalid = rvalid_vec[0];
    assign p1_rvalid = rvalid_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and per-port
// read-data scoreboards.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_access, cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_access(cpu_access), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    // Single-port RAM with registered read (read-before-write).
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: each rvalid pops the read data expected for that port.
    always @(negedge clock) begin
        if (p0_rvalid) begin
            if (q0.size() == 0) check("p0_spurious_rvalid", 32'(p0_rvalid), 32'd0);
            else begin
                check("p0_rdata", p0_rdata, q0.pop_front());
                $display("p0 read data 0x%08h at %0t", p0_rdata, $time);
            end
        end
        if (p1_rvalid) begin
            if (q1.size() == 0) check("p1_spurious_rvalid", 32'(p1_rvalid), 32'd0);
            else begin
                check("p1_rdata", p1_rdata, q1.pop_front());
                $display("p1 read data 0x%08h at %0t", p1_rdata, $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        reset = 1'b1;
        cpu_access = 0; cpu_wren = 0; cpu_addr = 0; cpu_wdata = 0;
        p0_req = 1; p0_we = 0; p0_addr = 12'd5; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0;     p1_wdata = 0;

        // Reset state, with a pending request that must not be granted.
        #2;
        check("reset_p0_gnt", 32'(p0_gnt), 32'd0);
        check("reset_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("reset_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("reset_cpu_stall", 32'(cpu_stall), 32'd0);
        check("reset_ram_wEn", 32'(ram_wEn), 32'd0);
        step(); step();
        p0_req = 0;
        reset  = 1'b0;

        // CPU store then load of addr 5.
        step();
        cpu_access = 1; cpu_wren = 1; cpu_addr = 12'd5; cpu_wdata = 32'hDEAD;
        #1;
        check("cpu_wr_wEn", 32'(ram_wEn), 32'd1);
        check("cpu_wr_addr", 32'(ram_addr), 32'd5);
        check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        $display("cpu write addr 5 data 0xDEAD");
        step();
        cpu_wren = 0;
        #1;
        check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        step();
        cpu_access = 0;
        #1;
        check("cpu_rdata", cpu_rdata, 32'hDEAD);
        $display("cpu read addr 5 data 0x%08h", cpu_rdata);

        // p1 read of addr 5 with CPU idle.
        step();
        p1_req = 1; p1_we = 0; p1_addr = 12'd5;
        #1;
        check("p1_rd_gnt", 32'(p1_gnt), 32'd1);
        check("p1_rd_p0_gnt", 32'(p0_gnt), 32'd0);
        q1.push_back(32'hDEAD);
        $display("p1 read request addr 5");
        step();
        p1_req = 0;

        // Round robin: both request continuously, grants alternate from p0.
        p0_req = 1; p0_we = 0; p0_addr = 12'd5;
        p1_req = 1; p1_we = 0; p1_addr = 12'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_p0_gnt", 32'(p0_gnt), 32'((i % 2) == 0));
            check("rr_p1_gnt", 32'(p1_gnt), 32'((i % 2) == 1));
            if ((i % 2) == 0) q0.push_back(32'hDEAD);
            else              q1.push_back(32'hDEAD);
            $display("rr cycle %0d p0_gnt=%0b p1_gnt=%0b", i, p0_gnt, p1_gnt);
            step();
        end
        p0_req = 0; p1_req = 0;
        step();

        // Starvation: CPU accesses every cycle, p0 waits to write addr 7.
        cpu_access = 1; cpu_wren = 0; cpu_addr = 12'd3;
        p0_req = 1; p0_we = 1; p0_addr = 12'd7; p0_wdata = 32'h1234;
        for (int c = 1; c <= 8; c++) begin
            #1;
            check("starve_wait_gnt", 32'(p0_gnt), 32'd0);
            check("starve_wait_stall", 32'(cpu_stall), 32'd0);
            step();
        end
        #1;
        check("starve_force_gnt", 32'(p0_gnt), 32'd1);
        check("starve_force_stall", 32'(cpu_stall), 32'd1);
        check("starve_force_addr", 32'(ram_addr), 32'd7);
        check("starve_force_data", ram_dataIn, 32'h1234);
        check("starve_force_wEn", 32'(ram_wEn), 32'd1);
        $display("forced p0 write addr 7 data 0x1234 in cycle 9");
        step();
        p0_req = 0;
        #1;
        check("starve_resume_stall", 32'(cpu_stall), 32'd0);
        check("starve_resume_addr", 32'(ram_addr), 32'd3);
        step();
        cpu_access = 0;

        // p1 reads back the word p0 wrote.
        p1_req = 1; p1_we = 0; p1_addr = 12'd7;
        #1;
        check("p1_rd7_gnt", 32'(p1_gnt), 32'd1);
        q1.push_back(32'h1234);
        $display("p1 read request addr 7");
        step();
        p1_req = 0;
        step();

        // Reset mid-read: p0 granted, reset pulsed before rvalid is consumed.
        p0_req = 1; p0_we = 0; p0_addr = 12'd5;
        #1;
        check("mid_p0_gnt", 32'(p0_gnt), 32'd1);
        step();
        p0_req = 0;
        check("mid_p0_rvalid_pre", 32'(p0_rvalid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_p0_rvalid_rst", 32'(p0_rvalid), 32'd0);
        p0_req = 1; p1_req = 1;
        #1;
        check("mid_p0_gnt_rst", 32'(p0_gnt), 32'd0);
        check("mid_p1_gnt_rst", 32'(p1_gnt), 32'd0);
        $display("reset pulsed during p0 read");
        step();
        check("mid_p0_rvalid_hold", 32'(p0_rvalid), 32'd0);
        reset = 1'b0;
        #1;
        // Both request after reset: p0 wins first contention again.
        check("post_rst_p0_gnt", 32'(p0_gnt), 32'd1);
        check("post_rst_p1_gnt", 32'(p1_gnt), 32'd0);
        q0.push_back(32'hDEAD);
        step();
        p0_req = 0; p1_req = 0;
        step(); step();

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
